// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading-zero counter and normalising left shifter with valid/ready.
// Optional out_zero flag is enabled by defining LZC_ZERO_FLAG_EN.
module lzc_norm_pipe #(
  parameter int unsigned W     = 80,
  parameter int unsigned SEG   = 16,
  parameter int unsigned TAG_W = 8,
  localparam int unsigned CW   = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [W-1:0]     out_norm,
  output logic [TAG_W-1:0] out_tag
`ifdef LZC_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int unsigned NSEG = W / SEG;
  localparam int unsigned SCW  = $clog2(SEG) + 1;

  if ((W % SEG) != 0) begin : g_chk_w
    $error("lzc_norm_pipe: W must be a multiple of SEG");
  end
  if ((SEG < 4) || ((SEG & (SEG - 1)) != 0)) begin : g_chk_seg
    $error("lzc_norm_pipe: SEG must be a power of two and at least 4");
  end

  logic adv1, adv2;
  logic v1_q, v2_q;

  // Stage 1 state
  logic [W-1:0]     s1_data_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [NSEG-1:0]  s1_zero_q;
  logic [SCW-1:0]   s1_cnt_q [NSEG];

  logic [NSEG-1:0]  seg_zero_d;
  logic [SCW-1:0]   seg_cnt_d [NSEG];

  // Stage 2 state (drives the outputs)
  logic [CW-1:0]    count_q, count_d;
  logic [W-1:0]     norm_q, norm_d;
  logic [TAG_W-1:0] tag_q;
  logic             zero_q, zero_d;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Segment 0 is the most significant SEG bits.
  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      seg_cnt_d[s] = SCW'(SEG);
      // Ascending scan: the highest set bit is the last to write the count.
      for (int b = 0; b < SEG; b++) begin
        if (in_data[W - SEG - s * SEG + b]) begin
          seg_cnt_d[s] = SCW'(SEG - 1 - b);
        end
      end
      seg_zero_d[s] = ~|in_data[W - 1 - s * SEG -: SEG];
    end
  end

  // Descending scan so the most significant non-zero segment wins.
  always_comb begin
    count_d = CW'(W);
    for (int s = NSEG - 1; s >= 0; s--) begin
      if (!s1_zero_q[s]) begin
        count_d = CW'(s * SEG) + CW'(s1_cnt_q[s]);
      end
    end
    zero_d = &s1_zero_q;
    norm_d = s1_data_q << count_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      s1_data_q <= '0;
      s1_tag_q  <= '0;
      s1_zero_q <= '0;
      for (int s = 0; s < NSEG; s++) begin
        s1_cnt_q[s] <= '0;
      end
      count_q   <= '0;
      norm_q    <= '0;
      tag_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      if (adv1) begin
        v1_q      <= in_valid;
        s1_data_q <= in_data;
        s1_tag_q  <= in_tag;
        s1_zero_q <= seg_zero_d;
        for (int s = 0; s < NSEG; s++) begin
          s1_cnt_q[s] <= seg_cnt_d[s];
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          count_q <= count_d;
          norm_q  <= norm_d;
          tag_q   <= s1_tag_q;
          zero_q  <= zero_d;
        end
      end
    end
  end

  assign out_valid = v2_q;
  assign out_count = count_q;
  assign out_norm  = norm_q;
  assign out_tag   = tag_q;

`ifdef LZC_ZERO_FLAG_EN
  assign out_zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed and randomized self-checking bench for lzc_norm_pipe (W=80, SEG=16, TAG_W=8).
module tb_lzc_norm_pipe;

  localparam int W     = 80;
  localparam int TAG_W = 8;
  localparam int CW    = 7;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic [W-1:0]     out_norm;
  logic [TAG_W-1:0] out_tag;
`ifdef LZC_ZERO_FLAG_EN
  logic             out_zero;
`endif

  int checks = 0;
  int errors = 0;

  lzc_norm_pipe #(.W(80), .SEG(16), .TAG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_norm  (out_norm),
    .out_tag   (out_tag)
`ifdef LZC_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference count from the msb.
  function automatic int lz_ref(input logic [W-1:0] d);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!done && !d[i]) n++;
      else done = 1'b1;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_count: got %0d exp 0", out_count); end
    checks++; if (out_norm !== '0) begin errors++; $display("FAIL reset_norm: got %h exp 0", out_norm); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h exp 0", out_tag); end
`ifdef LZC_ZERO_FLAG_EN
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b exp 0", out_zero); end
`endif
  endtask

  task automatic run_vec(input logic [W-1:0] d, input logic [TAG_W-1:0] t, input int exp_cnt,
                         input logic [W-1:0] exp_norm);
    in_valid = 1'b1; in_data = d; in_tag = t;
    step();
    in_valid = 1'b0; in_data = '1; in_tag = 8'hff;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec_early_valid: got %b exp 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec_valid: got %b exp 1", out_valid); end
    checks++;
    if (out_count !== CW'(exp_cnt)) begin
      errors++; $display("FAIL vec_count: data %h got %0d exp %0d", d, out_count, exp_cnt);
    end
    checks++;
    if (out_norm !== exp_norm) begin
      errors++; $display("FAIL vec_norm: data %h got %h exp %h", d, out_norm, exp_norm);
    end
    checks++; if (out_tag !== t) begin errors++; $display("FAIL vec_tag: got %h exp %h", out_tag, t); end
`ifdef LZC_ZERO_FLAG_EN
    checks++;
    if (out_zero !== (exp_cnt == W)) begin
      errors++; $display("FAIL vec_zero: got %b exp %b", out_zero, (exp_cnt == W));
    end
`endif
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec_single: got %b exp 0", out_valid); end
  endtask

  task automatic test_directed();
    out_ready = 1'b1;
    run_vec(80'h8000_0000_0000_0000_0000, 8'h11, 0,  80'h8000_0000_0000_0000_0000);
    run_vec(80'h0000_0000_0000_0000_0001, 8'h22, 79, 80'h8000_0000_0000_0000_0000);
    run_vec(80'h0000_0000_0000_0000_0000, 8'h33, 80, 80'h0000_0000_0000_0000_0000);
    run_vec(80'h0000_8000_0000_0000_0000, 8'h44, 16, 80'h8000_0000_0000_0000_0000);
    run_vec(80'h0001_0000_0000_0000_0000, 8'h55, 15, 80'h8000_0000_0000_0000_0000);
    run_vec(80'h0000_0001_0000_0000_0000, 8'h66, 31, 80'h8000_0000_0000_0000_0000);
    run_vec(80'h0000_0000_0000_0000_ffff, 8'h77, 64, 80'hffff_0000_0000_0000_0000);
    run_vec(80'h0123_4567_89ab_cdef_0000, 8'h88, 7,  80'h91a2_b3c4_d5e6_f780_0000);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]     qd [$];
    logic [TAG_W-1:0] qt [$];
    logic [W-1:0]     d, ed;
    logic [TAG_W-1:0] et;
    logic [95:0]      r;
    int               n, got;
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i <= 101; i++) begin
      checks++;
      if (out_valid !== (i >= 2)) begin
        errors++; $display("FAIL b2b_valid: cycle %0d got %b exp %b", i, out_valid, (i >= 2));
      end
      if (out_valid === 1'b1 && qd.size() > 0) begin
        ed = qd.pop_front(); et = qt.pop_front(); n = lz_ref(ed); got++;
        checks++;
        if (out_count !== CW'(n) || out_norm !== (ed << n) || out_tag !== et) begin
          errors++;
          $display("FAIL b2b_result: data %h got cnt %0d norm %h tag %h exp cnt %0d norm %h tag %h",
                   ed, out_count, out_norm, out_tag, n, ed << n, et);
        end
      end
      if (i < 100) begin
        r = {$urandom, $urandom, $urandom};
        d = r[W-1:0] >> $urandom_range(0, 80);
        in_valid = 1'b1; in_data = d; in_tag = TAG_W'(i);
        qd.push_back(d); qt.push_back(TAG_W'(i));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: cycle %0d got 0 exp 1", i); end
      step();
    end
    checks++; if (got != 100) begin errors++; $display("FAIL b2b_count: got %0d exp 100", got); end
  endtask

  task automatic test_stall();
    logic [W-1:0]     src [4];
    logic [TAG_W-1:0] qt [$];
    logic [W-1:0]     qd [$];
    logic [W-1:0]     ed;
    int               sent, got, n;
    src[0] = 80'h0000_0000_00f0_0000_0000;
    src[1] = 80'h4000_0000_0000_0000_0001;
    src[2] = 80'h0000_0000_0000_0000_0000;
    src[3] = 80'h0002_0000_0000_0000_0000;
    sent = 0; got = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      out_ready = (i >= 5);
      #1;
      if (out_valid === 1'b1) begin
        ed = qd[0]; n = lz_ref(ed);
        checks++;
        if (out_count !== CW'(n) || out_norm !== (ed << n) || out_tag !== qt[0]) begin
          errors++;
          $display("FAIL stall_result: cycle %0d got cnt %0d tag %h exp cnt %0d tag %h",
                   i, out_count, out_tag, n, qt[0]);
        end
        if (out_ready) begin
          void'(qd.pop_front()); void'(qt.pop_front()); got++;
        end
      end
      if (i <= 6) begin
        checks++;
        if (in_ready !== !(i >= 2 && i <= 4)) begin
          errors++; $display("FAIL stall_ready: cycle %0d got %b exp %b", i, in_ready, !(i >= 2 && i <= 4));
        end
      end
      if (sent < 4) begin
        in_valid = 1'b1; in_data = src[sent]; in_tag = TAG_W'(8'ha0 + sent);
        if (in_ready) begin
          qd.push_back(src[sent]); qt.push_back(TAG_W'(8'ha0 + sent)); sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL stall_count: got %0d exp 4", got); end
    in_valid = 1'b0;
    repeat (3) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup: got %b exp 0", out_valid); end
      step();
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 80'h0000_0000_0000_0000_0f00; in_tag = 8'hc1;
    step();
    in_data = 80'h0000_0000_0010_0000_0000; in_tag = 8'hc2;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_full_ready: got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_full_valid: got %b exp 1", out_valid); end
    rst = 1'b1; out_ready = 1'b1; in_data = 80'h1; in_tag = 8'hc3;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b exp 1", in_ready); end
    checks++;
    if (out_count !== '0 || out_norm !== '0 || out_tag !== '0) begin
      errors++; $display("FAIL rst_mid_outs: got cnt %0d norm %h tag %h exp 0", out_count, out_norm, out_tag);
    end
    repeat (4) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale: got %b exp 0", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
